gift_decrypt_control: RTL and testbench
=======================================

# gift_decrypt_control

Sequencing controller for the one-round-per-cycle GIFT decryption datapath, the inverse counterpart of the encryption control block. On a ciphertext write it first steps the key schedule forward to the last round key. It then applies the inverse round ROUNDS times, stepping the key schedule and the round-constant LFSR backwards, and finally strobes the output register. Inverse S-box, inverse permutation and the key-schedule registers live in the datapath; this block only issues enables and the round constant.

## Interface
- ROUNDS, 28, number of cipher rounds (28 = GIFT-64, 40 = GIFT-128); legal range 2..255.
- inClk  in  1  single clock; all state updates on its rising edge.
- inRst  in  1  synchronous, active-high reset.
- inExtKeyWr  in  1  external key write request.
- inExtDataWr  in  1  external ciphertext write request; starts a decryption.
- outIntKeyschRegExtWr  out  1  load external key into key-schedule register.
- outIntKeyschFwdEn  out  1  advance key schedule one step forward.
- outIntKeyschBwdEn  out  1  step key schedule one step backward (inverse update).
- outIntRoundRegExtWr  out  1  load ciphertext into round register.
- outIntInvRoundEn  out  1  apply one inverse round to round register.
- outIntRoundConst  out  6  round constant for the current inverse round.
- outIntDataOutRegWr  out  1  capture round register into output register.
- outBusy  out  1  high whenever not in IDLE.

## Operation
- State: FSM {IDLE, FWD, DEC, OUT}, 8-bit counter cnt, 6-bit constant register rc.
- Forward LFSR step: rc <= {rc[4:0], rc[5]^rc[4]^1}. Inverse step: rc <= {rc[0]^rc[5]^1, rc[5:1]}.
- IDLE:
  - outIntKeyschRegExtWr = inExtKeyWr; outIntRoundRegExtWr = inExtDataWr (combinational passthrough).
  - On inExtDataWr: cnt <= 0, go to FWD. Key and data may be written in the same cycle; both loads occur.
- FWD:
  - outIntKeyschFwdEn = 1; rc steps forward each cycle.
  - Lasts ROUNDS-1 cycles (cnt 0..ROUNDS-2), then cnt <= 0 and go to DEC.
  - On DEC entry, rc holds C_ROUNDS (0x0B for 28, 0x1A for 40).
- DEC:
  - outIntInvRoundEn = 1; outIntRoundConst = rc; rc steps inverse each cycle.
  - outIntKeyschBwdEn = 1 on every DEC cycle except the last. The key register therefore ends at round key 1, so the next block needs no key rewrite.
  - Lasts ROUNDS cycles, then go to OUT.
- OUT: outIntDataOutRegWr = 1 for one cycle; rc <= 0x01; go to IDLE.
- While busy: inExtKeyWr and inExtDataWr are ignored; both ext-write outputs are forced to 0.
- outIntRoundConst is 0 outside DEC.
- All enables not listed for a state are 0.

## Timing
- Reset values: state IDLE, cnt 0, rc 0x01.
- Output values during reset:
  - outBusy, all enables and outIntDataOutRegWr = 0; outIntRoundConst = 0.
  - Ext-write passthroughs are forced 0 while inRst is high.
- Reset mid-operation: return to IDLE at the next edge; no outIntDataOutRegWr pulse.
  - The key register is then left at an intermediate round key and must be rewritten before the next decryption.
- Latency: with the data write accepted at edge E0, outBusy is high from E0 until edge E(2·ROUNDS).
  - FWD: ROUNDS-1 cycles; DEC: ROUNDS cycles; OUT: 1 cycle.
  - outIntDataOutRegWr is high in the cycle after edge E(2·ROUNDS-1) (cycle 56 for ROUNDS=28).
- Back-to-back operation: a new inExtDataWr is accepted in the first IDLE cycle after OUT. Throughput is one block per 2·ROUNDS+1 cycles.
- Constant sequence across DEC, ROUNDS=28: 0x0B, 0x05, 0x02, 0x21, … , 0x03, 0x01.
- cnt compares use exact equality against ROUNDS-2 and ROUNDS-1; no wrap is possible within legal ROUNDS.

## Test plan
- Reset then idle: hold inRst 3 cycles -> all outputs 0 and rc = 0x01; after release, inExtKeyWr = 1 -> outIntKeyschRegExtWr = 1 the same cycle and outBusy stays 0.
- Single block, ROUNDS=28: inExtDataWr pulse ->
  - outIntRoundRegExtWr = 1 the same cycle;
  - 27 cycles of outIntKeyschFwdEn;
  - 28 cycles of outIntInvRoundEn with constants 0x0B … 0x01 and 27 outIntKeyschBwdEn pulses;
  - outIntDataOutRegWr in cycle 56; outBusy high for exactly 56 cycles.
- Writes while busy: pulse inExtKeyWr and inExtDataWr mid-DEC -> no ext-write output pulses, sequence and latency unchanged.
- Simultaneous key + data write in IDLE: both ext-write outputs assert in the same cycle and the normal sequence follows. A second block started immediately after OUT -> identical constants and latency.
- Reset at DEC cycle 10 -> IDLE next edge, no outIntDataOutRegWr, rc = 0x01; a new block then runs the full 56-cycle sequence.
- ROUNDS=40: first DEC constant 0x1A, last 0x01; 39 FWD cycles, 40 DEC cycles; outIntDataOutRegWr in cycle 80.

Source files
------------

// File: rtl/gift_decrypt_control.sv
// Sequencing controller for a one-round-per-cycle GIFT decryption datapath:
// winds the key schedule forward to the last round key, then runs ROUNDS inverse rounds.
module gift_decrypt_control #(
  parameter int unsigned ROUNDS = 28
) (
  input  logic       inClk,
  input  logic       inRst,
  input  logic       inExtKeyWr,
  input  logic       inExtDataWr,
  output logic       outIntKeyschRegExtWr,
  output logic       outIntKeyschFwdEn,
  output logic       outIntKeyschBwdEn,
  output logic       outIntRoundRegExtWr,
  output logic       outIntInvRoundEn,
  output logic [5:0] outIntRoundConst,
  output logic       outIntDataOutRegWr,
  output logic       outBusy
);

  typedef enum logic [1:0] {IDLE, FWD, DEC, OUT} state_e;

  localparam logic [7:0] LAST_FWD = 8'(ROUNDS - 2);
  localparam logic [7:0] LAST_DEC = 8'(ROUNDS - 1);
  localparam logic [5:0] RC_INIT  = 6'h01;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] rc_q, rc_d;

  function automatic logic [5:0] rc_fwd(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

  function automatic logic [5:0] rc_bwd(input logic [5:0] rc);
    return {rc[0] ^ rc[5] ^ 1'b1, rc[5:1]};
  endfunction

  always_comb begin
    // NOTE: every always_comb target is given a default first so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    case (state_q)
      IDLE: begin
        if (inExtDataWr) begin
          cnt_d   = '0;
          state_d = FWD;
        end
      end
      FWD: begin
        rc_d = rc_fwd(rc_q);
        if (cnt_q == LAST_FWD) begin
          cnt_d   = '0;
          state_d = DEC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DEC: begin
        rc_d = rc_bwd(rc_q);
        if (cnt_q == LAST_DEC) begin
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      OUT: begin
        rc_d    = RC_INIT;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rc_q    <= RC_INIT;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
    end
  end

  // Outputs decode the current state; reset gates them immediately, even mid-block.
  always_comb begin
    outIntKeyschRegExtWr = 1'b0;
    outIntKeyschFwdEn    = 1'b0;
    outIntKeyschBwdEn    = 1'b0;
    outIntRoundRegExtWr  = 1'b0;
    outIntInvRoundEn     = 1'b0;
    outIntRoundConst     = '0;
    outIntDataOutRegWr   = 1'b0;
    outBusy              = 1'b0;
    if (!inRst) begin
      outBusy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          outIntKeyschRegExtWr = inExtKeyWr;
          outIntRoundRegExtWr  = inExtDataWr;
        end
        FWD: outIntKeyschFwdEn = 1'b1;
        DEC: begin
          outIntInvRoundEn  = 1'b1;
          outIntRoundConst  = rc_q;
          // Skipping the last backward step leaves round key 1 loaded for the next block.
          outIntKeyschBwdEn = (cnt_q != LAST_DEC);
        end
        OUT: outIntDataOutRegWr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gift_decrypt_control.sv
// Bench for gift_decrypt_control: ROUNDS=28 and ROUNDS=40 instances share stimulus and are
// compared every cycle against a block-position model, plus literal sequence/latency checks.
module tb_gift_decrypt_control;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic key_wr  = 1'b0;
  logic data_wr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Index 0 is the ROUNDS=28 instance, index 1 the ROUNDS=40 instance.
  logic       o_key_ext   [2];
  logic       o_fwd       [2];
  logic       o_bwd       [2];
  logic       o_round_ext [2];
  logic       o_inv       [2];
  logic [5:0] o_const     [2];
  logic       o_out       [2];
  logic       o_busy      [2];

  int rnd [2] = '{28, 40};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gift_decrypt_control #(.ROUNDS((g == 0) ? 28 : 40)) dut (
      .inClk                (clk),
      .inRst                (rst),
      .inExtKeyWr           (key_wr),
      .inExtDataWr          (data_wr),
      .outIntKeyschRegExtWr (o_key_ext[g]),
      .outIntKeyschFwdEn    (o_fwd[g]),
      .outIntKeyschBwdEn    (o_bwd[g]),
      .outIntRoundRegExtWr  (o_round_ext[g]),
      .outIntInvRoundEn     (o_inv[g]),
      .outIntRoundConst     (o_const[g]),
      .outIntDataOutRegWr   (o_out[g]),
      .outBusy              (o_busy[g])
    );
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Constant of round i (1-based): i-1 forward LFSR steps from 0x01.
  function automatic int rc_of(input int i);
    logic [5:0] c;
    c = 6'h01;
    for (int k = 1; k < i; k++) c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
    return int'(c);
  endfunction

  // Model: position inside a block, 0 = idle, 1..R-1 forward, R..2R-1 inverse rounds, 2R output.
  int pos [2] = '{0, 0};

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst)                    pos[i] = 0;
        else if (pos[i] == 0)       pos[i] = data_wr ? 1 : 0;
        else if (pos[i] == 2*rnd[i]) pos[i] = 0;
        else                        pos[i] = pos[i] + 1;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int  p, r;
        bit  act, dec;
        p   = pos[i];
        r   = rnd[i];
        act = !rst;
        dec = act && p >= r && p <= 2*r - 1;
        check($sformatf("r%0d_busy", r),      o_busy[i],      int'(act && p != 0));
        check($sformatf("r%0d_key_ext", r),   o_key_ext[i],   int'(act && p == 0 && key_wr));
        check($sformatf("r%0d_round_ext", r), o_round_ext[i], int'(act && p == 0 && data_wr));
        check($sformatf("r%0d_fwd", r),       o_fwd[i],       int'(act && p >= 1 && p <= r - 1));
        check($sformatf("r%0d_inv", r),       o_inv[i],       int'(dec));
        check($sformatf("r%0d_bwd", r),       o_bwd[i],       int'(dec && p != 2*r - 1));
        check($sformatf("r%0d_const", r),     o_const[i],     dec ? rc_of(2*r - p) : 0);
        check($sformatf("r%0d_out", r),       o_out[i],       int'(act && p == 2*r));
      end
    end
  end

  task automatic step(input logic r, input logic k, input logic d);
    @(posedge clk);
    #1;
    rst     = r;
    key_wr  = k;
    data_wr = d;
  endtask

  int s_busy [2], s_fwd [2], s_dec [2], s_bwd [2], s_out [2], s_out_at [2], s_ext [2];
  int s_first [2], s_last [2];

  // Starts a block (optionally with a key write) and gathers per-instance statistics until both are idle.
  task automatic run_block(input logic with_key, input int busy_wr_at, input int rst_at,
                           input int rewrite_at);
    int n;
    bit live;
    for (int i = 0; i < 2; i++) begin
      s_busy[i] = 0; s_fwd[i] = 0; s_dec[i] = 0; s_bwd[i] = 0; s_out[i] = 0;
      s_out_at[i] = -1; s_ext[i] = 0; s_first[i] = -1; s_last[i] = -1;
    end
    step(1'b0, with_key, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("start_round_ext_r%0d", rnd[i]), o_round_ext[i], 1);
      check($sformatf("start_key_ext_r%0d", rnd[i]), o_key_ext[i], int'(with_key));
    end
    n    = 0;
    live = 1'b1;
    while (live && n < 200) begin
      n++;
      if (n == busy_wr_at)      step(1'b0, 1'b1, 1'b1);
      else if (n == rst_at)     step(1'b1, 1'b0, 1'b0);
      else if (n == rewrite_at) step(1'b0, 1'b0, 1'b1);
      else                      step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        s_busy[i] += int'(o_busy[i]);
        s_fwd[i]  += int'(o_fwd[i]);
        s_bwd[i]  += int'(o_bwd[i]);
        s_ext[i]  += int'(o_key_ext[i]) + int'(o_round_ext[i]);
        if (o_inv[i]) begin
          s_dec[i]++;
          if (s_first[i] < 0) s_first[i] = int'(o_const[i]);
          s_last[i] = int'(o_const[i]);
        end
        if (o_out[i]) begin
          s_out[i]++;
          s_out_at[i] = n;
        end
      end
      live = o_busy[0] || o_busy[1];
    end
    check("block_terminates", int'(live), 0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_full(input int i, input int r, input int first_c);
    check($sformatf("busy_cycles_r%0d", r), s_busy[i], 2*r);
    check($sformatf("fwd_cycles_r%0d", r),  s_fwd[i],  r - 1);
    check($sformatf("dec_cycles_r%0d", r),  s_dec[i],  r);
    check($sformatf("bwd_pulses_r%0d", r),  s_bwd[i],  r - 1);
    check($sformatf("out_pulses_r%0d", r),  s_out[i],  1);
    check($sformatf("out_cycle_r%0d", r),   s_out_at[i], 2*r);
    check($sformatf("first_const_r%0d", r), s_first[i], first_c);
    check($sformatf("last_const_r%0d", r),  s_last[i], 'h01);
    check($sformatf("ext_pulses_r%0d", r),  s_ext[i],  0);
  endtask

  initial begin
    check("model_c4",  rc_of(4),  'h0F);
    check("model_c28", rc_of(28), 'h0B);
    check("model_c40", rc_of(40), 'h1A);

    // Reset held three cycles, then a key write while idle.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_busy",  o_busy[i],  0);
      check("reset_const", o_const[i], 0);
      check("reset_out",   o_out[i],   0);
    end
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("idle_key_ext", o_key_ext[i], 1);
      check("idle_busy",    o_busy[i],    0);
    end
    step(1'b0, 1'b0, 1'b0);

    // Single block.
    run_block(1'b0, 0, 0, 0);
    check_full(0, 28, 'h0B);
    check_full(1, 40, 'h1A);

    // Key and data writes while both instances are mid-block are ignored.
    run_block(1'b0, 38, 0, 0);
    check_full(0, 28, 'h0B);
    check_full(1, 40, 'h1A);

    // Simultaneous key+data write, then a back-to-back block on the first idle cycle after OUT.
    run_block(1'b1, 0, 0, 57);
    check("b2b_busy_r28",  s_busy[0],   112);
    check("b2b_dec_r28",   s_dec[0],    56);
    check("b2b_bwd_r28",   s_bwd[0],    54);
    check("b2b_out_r28",   s_out[0],    2);
    check("b2b_out_at_r28", s_out_at[0], 113);
    check("b2b_ext_r28",   s_ext[0],    1);
    check("b2b_last_r28",  s_last[0],   'h01);
    check_full(1, 40, 'h1A);

    // Reset at inverse round 10 of the ROUNDS=28 instance.
    run_block(1'b0, 0, 38, 0);
    check("rst_busy_r28", s_busy[0], 37);
    check("rst_dec_r28",  s_dec[0],  10);
    check("rst_out_r28",  s_out[0],  0);
    check("rst_busy_r40", s_busy[1], 37);
    check("rst_out_r40",  s_out[1],  0);
    run_block(1'b0, 0, 0, 0);
    check_full(0, 28, 'h0B);
    check_full(1, 40, 'h1A);

    // Random traffic against the model, then drain.
    for (int c = 0; c < 2000; c++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    for (int c = 0; c < 100; c++) step(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
